control_sequencer: RTL and testbench

- Hardwired control unit that sits directly upstream of the datapath.
- Generates the per-step control strobes (T0..T6) for fetch and for register-format ALU instructions.
- Decodes the instruction word held in the datapath IR.
- Replaces the hand-sequenced control currently driven by benches with a real one-state-per-clock FSM that includes a memory-ready handshake, halt, and fault handling.

---
 rtl/control_sequencer_if.sv | 46 ++++
 rtl/control_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the hardwired sequencer and the datapath.
// master = sequencer (drives strobes), slave = datapath side (drives IR and
// memory/handshake inputs).
interface control_sequencer_if #(
  parameter int NUM_REGS = 16
);
  // Datapath -> sequencer
  logic [31:0]         ir;
  logic                mem_ready;
  logic                stop;
  // Sequencer -> datapath
  logic                pc_out;
  logic                zlo_out;
  logic                zhi_out;
  logic                mdr_out;
  logic                mar_enable;
  logic                pc_enable;
  logic                pc_increment;
  logic                mdr_enable;
  logic                read;
  logic                ir_enable;
  logic                y_enable;
  logic                z_enable;
  logic                lo_enable;
  logic                hi_enable;
  logic [4:0]          op_code;
  logic [NUM_REGS-1:0] reg_in;
  logic [NUM_REGS-1:0] reg_out;
  logic                run;
  logic                fault;
  logic [3:0]          state;

  modport master (
    input  ir, mem_ready, stop,
    output pc_out, zlo_out, zhi_out, mdr_out, mar_enable, pc_enable,
           pc_increment, mdr_enable, read, ir_enable, y_enable, z_enable,
           lo_enable, hi_enable, op_code, reg_in, reg_out, run, fault, state
  );

  modport slave (
    output ir, mem_ready, stop,
    input  pc_out, zlo_out, zhi_out, mdr_out, mar_enable, pc_enable,
           pc_increment, mdr_enable, read, ir_enable, y_enable, z_enable,
           lo_enable, hi_enable, op_code, reg_in, reg_out, run, fault, state
  );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: one state per clock, fetch (T0..T2) followed by
// register-format ALU execute (T3..T6), with memory-ready wait, halt at the
// instruction boundary and a sticky fault state for illegal opcodes and
// memory timeouts.
module control_sequencer #(
  parameter int WAIT_LIMIT = 0,
  parameter int NUM_REGS   = 16
) (
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_HALT  = 4'd8,
    S_FAULT = 4'd9
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // The wait counter only has to reach WAIT_LIMIT-1 (the last T1 cycle that
  // may still see mem_ready before the timeout fires).
  localparam int            WW        = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  function automatic logic is_legal(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: is_legal = 1'b1;
      default:                                       is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] idx);
    onehot = NUM_REGS'(1) << idx;
  endfunction

  // Live IR fields; only meaningful from T3 onward.
  logic [4:0] ir_op;
  logic [3:0] ir_ra, ir_rb, ir_rc;
  assign ir_op = bus.ir[31:27];
  assign ir_ra = bus.ir[26:23];
  assign ir_rb = bus.ir[22:19];
  assign ir_rc = bus.ir[18:15];

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [4:0]    op_q, op_d;
  logic [3:0]    ra_q, ra_d;
  logic [3:0]    rb_q, rb_d;
  logic [3:0]    rc_q, rc_d;

  logic op_is_long;   // mul/div: result spans LO and HI
  logic op_is_unary;  // neg/not: operand comes from rb, rc unused
  assign op_is_long  = (op_q == OP_MUL) || (op_q == OP_DIV);
  assign op_is_unary = (op_q == OP_NEG) || (op_q == OP_NOT);

  // Next-state, wait counter and IR field capture.
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    wait_d  = wait_q;
    op_d    = op_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    rc_d    = rc_q;
    case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        state_d = S_T1;
        wait_d  = '0;
      end
      S_T1: begin
        if (bus.mem_ready) begin
          state_d = S_T2;
        end else if ((WAIT_LIMIT > 0) && (wait_q == WAIT_LAST)) begin
          state_d = S_FAULT;
        end else if (WAIT_LIMIT > 0) begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: begin
        if (is_legal(ir_op)) begin
          state_d = S_T4;
          op_d    = ir_op;
          ra_d    = ir_ra;
          rb_d    = ir_rb;
          rc_d    = ir_rc;
        end else begin
          state_d = S_FAULT;
        end
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        if (op_is_long) state_d = S_T6;
        else            state_d = bus.stop ? S_HALT : S_T0;
      end
      S_T6:    state_d = bus.stop ? S_HALT : S_T0;
      S_HALT:  state_d = bus.stop ? S_HALT : S_T0;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // State register; clr forces RESET immediately.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_RESET;
      wait_q  <= '0;
      op_q    <= '0;
      ra_q    <= '0;
      rb_q    <= '0;
      rc_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      wait_q  <= wait_d;
      op_q    <= op_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      rc_q    <= rc_d;
    end
  end

  // Moore strobe decode from the present state and the captured IR fields;
  // T3 decodes the live IR, and mdr_enable in T1 follows mem_ready.
  always_comb begin
    bus.pc_out       = 1'b0;
    bus.zlo_out      = 1'b0;
    bus.zhi_out      = 1'b0;
    bus.mdr_out      = 1'b0;
    bus.mar_enable   = 1'b0;
    bus.pc_enable    = 1'b0;
    bus.pc_increment = 1'b0;
    bus.mdr_enable   = 1'b0;
    bus.read         = 1'b0;
    bus.ir_enable    = 1'b0;
    bus.y_enable     = 1'b0;
    bus.z_enable     = 1'b0;
    bus.lo_enable    = 1'b0;
    bus.hi_enable    = 1'b0;
    bus.op_code      = 5'b00000;
    bus.reg_in       = '0;
    bus.reg_out      = '0;
    bus.run          = 1'b0;
    bus.fault        = 1'b0;
    bus.state        = state_q;
    case (state_q)
      S_T0: begin
        bus.run          = 1'b1;
        bus.pc_out       = 1'b1;
        bus.mar_enable   = 1'b1;
        bus.pc_increment = 1'b1;
        bus.z_enable     = 1'b1;
      end
      S_T1: begin
        bus.run        = 1'b1;
        bus.zlo_out    = 1'b1;
        bus.pc_enable  = 1'b1;
        bus.read       = 1'b1;
        bus.mdr_enable = bus.mem_ready;
      end
      S_T2: begin
        bus.run       = 1'b1;
        bus.mdr_out   = 1'b1;
        bus.ir_enable = 1'b1;
      end
      S_T3: begin
        bus.run = 1'b1;
        if (is_legal(ir_op)) begin
          bus.reg_out  = onehot(ir_rb);
          bus.y_enable = 1'b1;
        end
      end
      S_T4: begin
        bus.run      = 1'b1;
        bus.op_code  = op_q;
        bus.z_enable = 1'b1;
        bus.reg_out  = onehot(op_is_unary ? rb_q : rc_q);
      end
      S_T5: begin
        bus.run     = 1'b1;
        bus.zlo_out = 1'b1;
        if (op_is_long) bus.lo_enable = 1'b1;
        else            bus.reg_in    = onehot(ra_q);
      end
      S_T6: begin
        bus.run       = 1'b1;
        bus.zhi_out   = 1'b1;
        bus.hi_enable = 1'b1;
      end
      S_FAULT: bus.fault = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed scenarios followed by
// random instructions, each cycle compared against the expected strobe set
// derived from the instruction, its memory wait and the stop request.
module tb_control_sequencer;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  control_sequencer_if #(.NUM_REGS(16)) ifa ();
  control_sequencer_if #(.NUM_REGS(16)) ifb ();

  control_sequencer #(.WAIT_LIMIT(LIM), .NUM_REGS(16)) dut_a (
    .clk(clk), .clr(clr), .bus(ifa.master)
  );
  control_sequencer #(.WAIT_LIMIT(0), .NUM_REGS(16)) dut_b (
    .clk(clk), .clr(clr), .bus(ifb.master)
  );

  // The no-timeout instance follows the same inputs.
  assign ifb.ir        = ifa.ir;
  assign ifb.mem_ready = ifa.mem_ready;
  assign ifb.stop      = ifa.stop;

  typedef struct packed {
    logic [6:0]  pad;
    logic [3:0]  state;
    logic        run;
    logic        fault;
    logic        pc_out;
    logic        zlo_out;
    logic        zhi_out;
    logic        mdr_out;
    logic        mar_enable;
    logic        pc_enable;
    logic        pc_increment;
    logic        mdr_enable;
    logic        read;
    logic        ir_enable;
    logic        y_enable;
    logic        z_enable;
    logic        lo_enable;
    logic        hi_enable;
    logic [4:0]  op_code;
    logic [15:0] reg_in;
    logic [15:0] reg_out;
  } obs_t;

  int n_total = 0;
  int n_pass  = 0;

  logic [4:0] legal_ops [13] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110,
                                 5'b00111, 5'b01000, 5'b01001, 5'b01010,
                                 5'b01011, 5'b01111, 5'b10000, 5'b10001,
                                 5'b10010};

  function automatic bit op_legal(input logic [4:0] op);
    for (int i = 0; i < 13; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o              = '0;
    o.state        = ifa.state;
    o.run          = ifa.run;
    o.fault        = ifa.fault;
    o.pc_out       = ifa.pc_out;
    o.zlo_out      = ifa.zlo_out;
    o.zhi_out      = ifa.zhi_out;
    o.mdr_out      = ifa.mdr_out;
    o.mar_enable   = ifa.mar_enable;
    o.pc_enable    = ifa.pc_enable;
    o.pc_increment = ifa.pc_increment;
    o.mdr_enable   = ifa.mdr_enable;
    o.read         = ifa.read;
    o.ir_enable    = ifa.ir_enable;
    o.y_enable     = ifa.y_enable;
    o.z_enable     = ifa.z_enable;
    o.lo_enable    = ifa.lo_enable;
    o.hi_enable    = ifa.hi_enable;
    o.op_code      = ifa.op_code;
    o.reg_in       = ifa.reg_in;
    o.reg_out      = ifa.reg_out;
    return o;
  endfunction

  // Expected idle image of a state: everything 0 except state/run/fault.
  function automatic obs_t base(input logic [3:0] st);
    obs_t o;
    o       = '0;
    o.state = st;
    o.run   = (st >= 4'd1) && (st <= 4'd7);
    o.fault = (st == 4'd9);
    return o;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare mid-cycle, then advance past the next edge.
  task automatic step(input string tag, input obs_t exp);
    @(negedge clk);
    check(tag, get_obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    clr = 1'b1;
    #2;
    check({tag, "/async"}, get_obs(), base(4'd0));
    @(posedge clk);
    #1;
    clr = 1'b0;
    step({tag, "/reset"}, base(4'd0));
  endtask

  // Runs one instruction starting in T0. waits = T1 cycles with mem_ready low.
  // Returns done=0 when the DUT ended in FAULT or the run was aborted by clr.
  task automatic run_instr(input string tag, input logic [31:0] instr,
                           input int waits, input bit stp, input bit abort,
                           output bit done);
    obs_t       e;
    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    int         n1;
    bit         long_op;
    op      = instr[31:27];
    ra      = instr[26:23];
    rb      = instr[22:19];
    rc      = instr[18:15];
    long_op = (op == 5'b01111) || (op == 5'b10000);
    done    = 1'b0;

    // T0: junk on every input that must be ignored here
    ifa.ir        = $urandom;
    ifa.mem_ready = 1'($urandom);
    ifa.stop      = 1'($urandom);
    e = base(4'd1);
    e.pc_out = 1; e.mar_enable = 1; e.pc_increment = 1; e.z_enable = 1;
    step({tag, "/T0"}, e);

    // T1: wait for memory, possibly timing out
    n1 = (waits < LIM) ? waits + 1 : LIM;
    for (int i = 0; i < n1; i++) begin
      ifa.mem_ready = (i == waits);
      ifa.stop      = 1'($urandom);
      e = base(4'd2);
      e.zlo_out = 1; e.pc_enable = 1; e.read = 1; e.mdr_enable = (i == waits);
      step({tag, "/T1"}, e);
    end
    if (waits >= LIM) begin
      step({tag, "/timeout"}, base(4'd9));
      return;
    end

    // T2: IR loads at the end of this cycle
    ifa.mem_ready = 1'($urandom);
    e = base(4'd3);
    e.mdr_out = 1; e.ir_enable = 1;
    step({tag, "/T2"}, e);
    ifa.ir = instr;

    // T3
    e = base(4'd4);
    if (op_legal(op)) begin
      e.reg_out  = 16'h1 << rb;
      e.y_enable = 1;
    end
    step({tag, "/T3"}, e);
    if (!op_legal(op)) begin
      step({tag, "/illegal"}, base(4'd9));
      return;
    end

    // T4
    ifa.stop = stp ? 1'b1 : 1'($urandom);
    e = base(4'd5);
    e.op_code  = op;
    e.z_enable = 1;
    e.reg_out  = 16'h1 << (((op == 5'b10001) || (op == 5'b10010)) ? rb : rc);
    if (abort) begin
      @(negedge clk);
      check({tag, "/T4"}, get_obs(), e);
      #1;
      clr = 1'b1;
      #1;
      check({tag, "/clr_async"}, get_obs(), base(4'd0));
      return;
    end
    step({tag, "/T4"}, e);

    // T5 (and T6 for mul/div); stop is sampled at the last cycle
    if (!long_op) ifa.stop = stp;
    e = base(4'd6);
    e.zlo_out = 1;
    if (long_op) e.lo_enable = 1;
    else         e.reg_in    = 16'h1 << ra;
    step({tag, "/T5"}, e);
    if (long_op) begin
      ifa.stop = stp;
      e = base(4'd7);
      e.zhi_out = 1; e.hi_enable = 1;
      step({tag, "/T6"}, e);
    end

    if (stp) begin
      step({tag, "/halt"}, base(4'd8));
      ifa.stop = 1'b0;
      step({tag, "/halt_exit"}, base(4'd8));
    end
    done = 1'b1;
  endtask

  task automatic fault_hold(input string tag);
    for (int i = 0; i < 2; i++) begin
      ifa.stop      = 1'($urandom);
      ifa.mem_ready = 1'($urandom);
      step({tag, "/fault_hold"}, base(4'd9));
    end
  endtask

  initial begin
    bit         ok;
    logic [31:0] instr;
    int         w, r;
    bit         s;

    clr           = 1'b1;
    ifa.ir        = '0;
    ifa.mem_ready = 1'b0;
    ifa.stop      = 1'b0;
    #12;
    do_reset("init");

    // Fetch/execute or R1,R2,R3, zero wait
    run_instr("or", 32'h5891_8000, 0, 1'b0, 1'b0, ok);
    // Three-cycle memory wait
    run_instr("wait3", 32'h5891_8000, 3, 1'b0, 1'b0, ok);
    // mul R3,R4,R2
    run_instr("mul", 32'h79A1_0000, 0, 1'b0, 1'b0, ok);
    // not R1,R5 with rc=R7 ignored
    run_instr("not", {5'b10010, 4'd1, 4'd5, 4'd7, 15'd0}, 1, 1'b0, 1'b0, ok);
    // add R0,R0,R0
    run_instr("add_r0", {5'b00011, 12'd0, 15'h7FFF}, 0, 1'b0, 1'b0, ok);
    // Illegal opcode (ld)
    run_instr("ld", {5'b00000, 27'h123_4567}, 0, 1'b0, 1'b0, ok);
    fault_hold("ld");
    do_reset("ld");
    // Memory timeout, plus the no-timeout instance staying in T1
    run_instr("timeout", 32'h5891_8000, 6, 1'b0, 1'b0, ok);
    fault_hold("timeout");
    do_reset("timeout");
    ifa.mem_ready = 1'b0;
    @(posedge clk); #1;                        // T0 -> T1
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_b("nolimit/T1", 5'(ifb.state), 5'd2);
      @(posedge clk); #1;
    end
    ifa.mem_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_b("nolimit/T2", 5'(ifb.state), 5'd3);
    @(posedge clk); #1;
    do_reset("nolimit");
    // Halt requested during T4, resume on stop=0
    run_instr("halt", 32'h5891_8000, 0, 1'b1, 1'b0, ok);
    run_instr("after_halt", 32'h2091_8000, 2, 1'b0, 1'b0, ok);
    // Halt after a mul
    run_instr("halt_mul", 32'h79A1_0000, 0, 1'b1, 1'b0, ok);
    // Asynchronous clear mid-T4
    run_instr("abort", 32'h5891_8000, 0, 1'b0, 1'b1, ok);
    do_reset("abort");

    // Random instructions
    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 8)       w = 0;
      else if (r < 14) w = int'($urandom_range(1, 3));
      else             w = int'($urandom_range(4, 6));
      s = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 7) == 0) instr[31:27] = 5'($urandom);
      else                           instr[31:27] = legal_ops[$urandom_range(0, 12)];
      instr[26:0] = 27'($urandom);
      run_instr("rand", instr, w, s, 1'b0, ok);
      if (!ok) begin
        fault_hold("rand");
        do_reset("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
